// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdata on clk_48 and delivers one
// sign-extended sample per lrclk half, with truncation reporting.
module i2s_rx #(
  parameter int SAMPLE_W    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_48,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        lrclk,
  input  logic        sdata,
  input  logic        en,
  output logic [31:0] x,
  output logic        x_valid,
  output logic        x_ch,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] lr_sync_reg;
  logic [SYNC_STAGES-1:0] sd_sync_reg;

  logic                sclk_d_reg;
  logic                lr_last_reg,  lr_last_next;
  logic                primed_reg,   primed_next;
  logic [1:0]          state_reg,    state_next;
  logic [CNT_W-1:0]    cnt_reg,      cnt_next;
  logic [SAMPLE_W-1:0] sr_reg,       sr_next;
  logic                ch_reg,       ch_next;
  logic [31:0]         x_reg,        x_next;
  logic                x_ch_reg,     x_ch_next;
  logic                x_valid_reg,  x_valid_next;
  logic                frame_err_reg, frame_err_next;

  logic        sclk_s;
  logic        lr_s;
  logic        sd_s;
  logic        sclk_rise;
  logic        lr_edge;
  logic [31:0] sample_ext;

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      lr_sync_reg   <= '0;
      sd_sync_reg   <= '0;
      sclk_d_reg    <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      lr_sync_reg   <= {lr_sync_reg[SYNC_STAGES-2:0], lrclk};
      sd_sync_reg   <= {sd_sync_reg[SYNC_STAGES-2:0], sdata};
      sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign lr_s      = lr_sync_reg[SYNC_STAGES-1];
  assign sd_s      = sd_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  // The first rise after reset only learns the current lrclk level, so a
  // word already in flight at reset release can never look like a fresh edge.
  assign lr_edge   = sclk_rise & primed_reg & (lr_s != lr_last_reg);

  generate
    if (SAMPLE_W < 32) begin : g_ext
      assign sample_ext = {{(32-SAMPLE_W){sr_reg[SAMPLE_W-1]}}, sr_reg};
    end else begin : g_noext
      assign sample_ext = sr_reg;
    end
  endgenerate

  always_comb begin
    lr_last_next   = lr_last_reg;
    primed_next    = primed_reg;
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    sr_next        = sr_reg;
    ch_next        = ch_reg;
    x_next         = x_reg;
    x_ch_next      = x_ch_reg;
    x_valid_next   = 1'b0;
    frame_err_next = 1'b0;

    if (sclk_rise) begin
      lr_last_next = lr_s;
      primed_next  = 1'b1;
    end

    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (lr_edge) begin
            state_next = ST_SKIP;
            ch_next    = lr_s;
          end
        end
        ST_SKIP: begin
          if (lr_edge) begin
            ch_next = lr_s;
          end else if (sclk_rise) begin
            state_next = ST_SHIFT;
            cnt_next   = '0;
          end
        end
        ST_SHIFT: begin
          if (cnt_reg == CNT_W'(SAMPLE_W)) begin
            x_next       = sample_ext;
            x_ch_next    = ch_reg;
            x_valid_next = 1'b1;
            state_next   = ST_WAIT;
          end else if (lr_edge) begin
            frame_err_next = 1'b1;
            state_next     = ST_SKIP;
            ch_next        = lr_s;
          end else if (sclk_rise) begin
            sr_next  = {sr_reg[SAMPLE_W-2:0], sd_s};
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          if (lr_edge) begin
            state_next = ST_SKIP;
            ch_next    = lr_s;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      lr_last_reg   <= 1'b0;
      primed_reg    <= 1'b0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      sr_reg        <= '0;
      ch_reg        <= 1'b0;
      x_reg         <= '0;
      x_ch_reg      <= 1'b0;
      x_valid_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      lr_last_reg   <= lr_last_next;
      primed_reg    <= primed_next;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sr_reg        <= sr_next;
      ch_reg        <= ch_next;
      x_reg         <= x_next;
      x_ch_reg      <= x_ch_next;
      x_valid_reg   <= x_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign x         = x_reg;
  assign x_ch      = x_ch_reg;
  assign x_valid   = x_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S halves bit by bit and checks outputs every
// cycle against a per-half expectation queue.
module tb_i2s_rx;

  localparam int W = 24;
  localparam int S = 2;

  logic        clk_48 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        sclk   = 1'b0;
  logic        lrclk  = 1'b0;
  logic        sdata  = 1'b0;
  logic        en     = 1'b0;
  logic [31:0] x;
  logic        x_valid;
  logic        x_ch;
  logic        frame_err;

  i2s_rx #(.SAMPLE_W(W), .SYNC_STAGES(S)) dut (
    .clk_48(clk_48), .rst_n(rst_n), .sclk(sclk), .lrclk(lrclk),
    .sdata(sdata), .en(en), .x(x), .x_valid(x_valid), .x_ch(x_ch),
    .frame_err(frame_err)
  );

  always #5 clk_48 = ~clk_48;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [31:0] xv;
    bit          ch;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] x_exp = '0;
  bit          ch_exp = 1'b0;
  bit          primed_m = 1'b0;
  bit          prev_active = 1'b0;
  int          prev_n = 0;

  always @(posedge clk_48) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] w);
    logic [31:0] m;
    m = (W >= 32) ? 32'hFFFF_FFFF : ((32'h1 << W) - 32'h1);
    return w[W-1] ? (w | ~m) : (w & m);
  endfunction

  // Per-cycle compare against the expected event queue.
  always @(negedge clk_48) begin
    ev_t e;
    if (x_valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missed_event", 32'(cyc), 32'(e.cyc));
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      if (e.is_err) begin
        check("frame_err_pulse", {31'b0, frame_err}, 32'd1);
        check("no_valid_on_err", {31'b0, x_valid}, 32'd0);
        check("x_hold_on_err", x, x_exp);
      end else begin
        check("x_valid_pulse", {31'b0, x_valid}, 32'd1);
        check("no_err_on_valid", {31'b0, frame_err}, 32'd0);
        check("x_value", x, e.xv);
        check("x_ch_value", {31'b0, x_ch}, {31'b0, e.ch});
        x_exp  = e.xv;
        ch_exp = e.ch;
      end
    end else begin
      check("x_valid_idle", {31'b0, x_valid}, 32'd0);
      check("frame_err_idle", {31'b0, frame_err}, 32'd0);
      check("x_hold", x, x_exp);
      check("x_ch_hold", {31'b0, x_ch}, {31'b0, ch_exp});
    end
  end

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    x_exp    = '0;
    ch_exp   = 1'b0;
    exp_q.delete();
    primed_m = 1'b0;
    #1;
    check("rst_x", x, 32'h0);
    check("rst_x_valid", {31'b0, x_valid}, 32'd0);
    check("rst_x_ch", {31'b0, x_ch}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One lrclk half of n sclk periods. Bit 0 is the rise that sees the new
  // lrclk level, bit 1 is the I2S delay bit, bits 2..W+1 carry the word MSB first.
  task automatic drive_half(input bit lrv, input int n, input logic [31:0] word,
                            input int drop_at, input int raise_at, input int rst_at);
    bit active;
    bit d;
    active = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at) begin
        en     = 1'b0;
        active = 1'b0;
      end
      if (i == raise_at) en = 1'b1;
      if (i >= 2 && i <= W + 1) d = word[W + 1 - i];
      else                      d = 1'($urandom_range(1, 0));
      sclk  = 1'b0;
      lrclk = lrv;
      sdata = d;
      if (i == rst_at) begin
        do_reset();
        active = 1'b0;
      end
      tick();
      tick();
      sclk = 1'b1;
      if (i == 0) begin
        if (prev_active && prev_n < W + 2 && en)
          exp_q.push_back('{cyc: cyc + S + 1, is_err: 1'b1, xv: '0, ch: 1'b0});
        active = en && primed_m;
      end
      if (i == W + 1 && active)
        exp_q.push_back('{cyc: cyc + S + 2, is_err: 1'b0, xv: sext(word), ch: lrv});
      primed_m = 1'b1;
      tick();
      tick();
    end
    prev_active = active;
    prev_n      = n;
  endtask

  initial begin
    int v0;
    int e0;
    bit lr;
    tick();
    check("reset_x", x, 32'h0);
    check("reset_x_valid", {31'b0, x_valid}, 32'd0);
    check("reset_x_ch", {31'b0, x_ch}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Priming half: no edge has been observed yet, so nothing is captured.
    drive_half(1'b1, 32, 32'($urandom), -1, -1, -1);
    check("prime_no_valid", 32'(valid_cnt), 32'd0);

    drive_half(1'b0, 32, 32'h007FFFFF, -1, -1, -1);
    check("t1_x", x, 32'h007FFFFF);
    check("t1_ch", {31'b0, x_ch}, 32'd0);

    drive_half(1'b1, 32, 32'h00800000, -1, -1, -1);
    check("t2_x_neg", x, 32'hFF800000);
    check("t2_ch", {31'b0, x_ch}, 32'd1);
    drive_half(1'b0, 32, 32'h00000001, -1, -1, -1);
    check("t2_x_one", x, 32'h00000001);

    v0 = valid_cnt;
    e0 = err_cnt;
    drive_half(1'b1, 12, 32'($urandom), -1, -1, -1);
    check("t3_x_unchanged", x, 32'h00000001);
    drive_half(1'b0, 32, 32'h00123456, -1, -1, -1);
    check("t3_err_count", 32'(err_cnt - e0), 32'd1);
    check("t3_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t3_x_after", x, 32'h00123456);

    v0 = valid_cnt;
    drive_half(1'b1, 32, 32'($urandom), -1, -1, 14);
    check("t4_no_valid_after_rst", 32'(valid_cnt - v0), 32'd0);
    drive_half(1'b0, 32, 32'h00ABCDEF, -1, -1, -1);
    check("t4_x_after", x, 32'hFFABCDEF);
    check("t4_ch_after", {31'b0, x_ch}, 32'd0);

    v0 = valid_cnt;
    drive_half(1'b1, 32, 32'($urandom), 10, -1, -1);
    drive_half(1'b0, 32, 32'($urandom), -1, -1, -1);
    drive_half(1'b1, 32, 32'($urandom), -1, 5, -1);
    check("t5_none_while_off", 32'(valid_cnt - v0), 32'd0);
    drive_half(1'b0, 32, 32'h0000F00F, -1, -1, -1);
    check("t5_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("t5_x", x, 32'h0000F00F);

    v0 = valid_cnt;
    lr = 1'b1;
    for (int h = 0; h < 20; h++) begin
      drive_half(lr, 32, 32'($urandom), -1, -1, -1);
      lr = ~lr;
    end
    check("t6_valid_count", 32'(valid_cnt - v0), 32'd20);

    for (int k = 0; k < 12; k++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
